tft_pixel_streamer: RTL and testbench



---
 rtl/tft_pixel_streamer.sv | 178 +++++++++++++++++
 tb/tb_tft_pixel_streamer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tft_pixel_streamer.sv
// ILI9341 4-wire SPI frame writer: address-window header followed by
// LCD_W*LCD_H RGB565 pixels pulled one at a time from the renderer.
module tft_pixel_streamer #(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned LCD_W      = 240,
  parameter int unsigned LCD_H      = 320,
  parameter int unsigned GAP_CYC    = 16,
  parameter int unsigned CONTINUOUS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pixel_color,
  output logic        framebufferClk,
  output logic        tft_cs,
  output logic        tft_dc,
  output logic        tft_sck,
  output logic        tft_mosi,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned NPIX     = LCD_W * LCD_H;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] XEND     = 16'(LCD_W - 1);
  localparam logic [15:0] YEND     = 16'(LCD_H - 1);
  localparam logic [16:0] PIX_LAST = 17'(NPIX - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXELS, S_GAP, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [3:0]        r_bit;
  logic [3:0]        r_byte;
  logic [16:0]       r_pix;
  logic [15:0]       r_gap;
  logic [15:0]       r_shift;
  logic              r_cs, r_dc, r_sck, r_mosi, r_fb, r_busy, r_done;
  logic              w_half_end, w_bit_end, w_unit_last;
  logic [3:0]        w_hdr_idx;
  logic [8:0]        w_hdr_next;

  // Header table entry as {dc, byte}
  function automatic logic [8:0] hdr_word(input logic [3:0] idx);
    case (idx)
      4'd0:    hdr_word = {1'b0, 8'h2A};
      4'd3:    hdr_word = {1'b1, XEND[15:8]};
      4'd4:    hdr_word = {1'b1, XEND[7:0]};
      4'd5:    hdr_word = {1'b0, 8'h2B};
      4'd8:    hdr_word = {1'b1, YEND[15:8]};
      4'd9:    hdr_word = {1'b1, YEND[7:0]};
      4'd10:   hdr_word = {1'b0, 8'h2C};
      default: hdr_word = {1'b1, 8'h00};
    endcase
  endfunction

  assign w_half_end  = (r_div == DIV_LAST);
  assign w_bit_end   = w_half_end & r_sck;
  assign w_unit_last = (r_state == S_HEADER) ? (r_bit == 4'd7) : (r_bit == 4'd15);
  assign w_hdr_idx   = (r_state == S_HEADER) ? (r_byte + 4'd1) : 4'd0;
  assign w_hdr_next  = hdr_word(w_hdr_idx);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_HEADER;
      S_HEADER: if (w_bit_end && w_unit_last && r_byte == 4'd10) w_state_nxt = S_PIXELS;
      S_PIXELS: if (w_bit_end && w_unit_last && r_pix == PIX_LAST) w_state_nxt = S_GAP;
      S_GAP:    if (r_gap == GAP_LAST) w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = (CONTINUOUS != 0) ? S_HEADER : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs, bit timing and shift datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_pix   <= '0;
      r_gap   <= '0;
      r_shift <= '0;
      r_cs    <= 1'b1;
      r_dc    <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_fb    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fb   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_byte  <= w_hdr_idx;
            r_shift <= {w_hdr_next[7:0], 8'h00};
            r_mosi  <= w_hdr_next[7];
            r_dc    <= w_hdr_next[8];
            r_bit   <= '0;
            r_div   <= '0;
            r_sck   <= 1'b0;
          end
        end
        S_HEADER, S_PIXELS: begin
          r_div <= w_half_end ? '0 : r_div + DIV_W'(1);
          if (w_half_end && !r_sck) r_sck <= 1'b1;
          if (w_bit_end) begin
            r_sck <= 1'b0;
            if (!w_unit_last) begin
              r_bit   <= r_bit + 4'd1;
              r_shift <= r_shift << 1;
              r_mosi  <= r_shift[14];
            end else if (w_state_nxt == S_GAP) begin
              r_cs   <= 1'b1;
              r_mosi <= 1'b0;
              r_gap  <= '0;
              r_pix  <= '0;
            end else if (w_state_nxt == S_HEADER) begin
              r_byte  <= w_hdr_idx;
              r_shift <= {w_hdr_next[7:0], 8'h00};
              r_mosi  <= w_hdr_next[7];
              r_dc    <= w_hdr_next[8];
              r_bit   <= '0;
            end else begin
              // New pixel: capture the renderer's current colour and advance it
              r_shift <= pixel_color;
              r_mosi  <= pixel_color[15];
              r_dc    <= 1'b1;
              r_fb    <= 1'b1;
              r_bit   <= '0;
              r_pix   <= (r_state == S_PIXELS) ? r_pix + 17'd1 : '0;
            end
          end
        end
        S_GAP: r_gap <= r_gap + 16'd1;
        S_DONE: begin
          r_done <= 1'b1;
          if (CONTINUOUS != 0) begin
            r_cs    <= 1'b0;
            r_byte  <= w_hdr_idx;
            r_shift <= {w_hdr_next[7:0], 8'h00};
            r_mosi  <= w_hdr_next[7];
            r_dc    <= w_hdr_next[8];
            r_bit   <= '0;
            r_div   <= '0;
            r_sck   <= 1'b0;
          end else begin
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign framebufferClk = r_fb;
  assign tft_cs         = r_cs;
  assign tft_dc         = r_dc;
  assign tft_sck        = r_sck;
  assign tft_mosi       = r_mosi;
  assign busy           = r_busy;
  assign frame_done     = r_done;

endmodule

// File: tb/tb_tft_pixel_streamer.sv
// Bench for tft_pixel_streamer: three instances on a 4x3 panel
// (A: CLK_DIV=2, B: CLK_DIV=1, C: CLK_DIV=2 continuous) fed by a renderer model.
module tb_tft_pixel_streamer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] start = 3'b000;
  logic [2:0] fb, cs, dc, sck, mosi, busy, done;
  logic [15:0] pix [3];
  logic [3:0]  ridx [3];

  always #5 clk = ~clk;

  tft_pixel_streamer #(.CLK_DIV(2), .LCD_W(4), .LCD_H(3), .GAP_CYC(16), .CONTINUOUS(0)) u_a (
    .clk(clk), .reset(rst), .start(start[0]), .pixel_color(pix[0]), .framebufferClk(fb[0]),
    .tft_cs(cs[0]), .tft_dc(dc[0]), .tft_sck(sck[0]), .tft_mosi(mosi[0]),
    .busy(busy[0]), .frame_done(done[0]));

  tft_pixel_streamer #(.CLK_DIV(1), .LCD_W(4), .LCD_H(3), .GAP_CYC(16), .CONTINUOUS(0)) u_b (
    .clk(clk), .reset(rst), .start(start[1]), .pixel_color(pix[1]), .framebufferClk(fb[1]),
    .tft_cs(cs[1]), .tft_dc(dc[1]), .tft_sck(sck[1]), .tft_mosi(mosi[1]),
    .busy(busy[1]), .frame_done(done[1]));

  tft_pixel_streamer #(.CLK_DIV(2), .LCD_W(4), .LCD_H(3), .GAP_CYC(16), .CONTINUOUS(1)) u_c (
    .clk(clk), .reset(rst), .start(start[2]), .pixel_color(pix[2]), .framebufferClk(fb[2]),
    .tft_cs(cs[2]), .tft_dc(dc[2]), .tft_sck(sck[2]), .tft_mosi(mosi[2]),
    .busy(busy[2]), .frame_done(done[2]));

  // Renderer model: pixel index advances on each framebufferClk, wraps after 12
  always_ff @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst)        ridx[i] <= 4'd0;
      else if (fb[i]) ridx[i] <= (ridx[i] == 4'd11) ? 4'd0 : ridx[i] + 4'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < 3; i++) pix[i] = 16'hA000 + {12'h000, ridx[i]};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  int   nfb [3], bad_sp [3], bad_al [3], cs_bad [3], bitcnt [3], fb_prev [3];
  int   done_n [3], cs_rise [3];
  int   done_cyc [3][4];
  logic done_busy [3][4];
  int   busy_drop;
  int   per [3] = '{64, 32, 64};
  logic [2:0] psck = 3'b000, pcs = 3'b111;
  logic qb0[$], qd0[$], qb1[$], qd1[$];
  logic clr = 1'b0, bmon = 1'b0;

  // Observe the SPI lines on the falling clock edge
  always @(negedge clk) begin
    if (clr) begin
      qb0.delete(); qd0.delete(); qb1.delete(); qd1.delete();
      busy_drop = 0;
      for (int i = 0; i < 3; i++) begin
        nfb[i] = 0; bad_sp[i] = 0; bad_al[i] = 0; cs_bad[i] = 0;
        bitcnt[i] = 0; fb_prev[i] = 0; done_n[i] = 0; cs_rise[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sck[i] && !psck[i]) begin
          bitcnt[i]++;
          if (cs[i]) cs_bad[i]++;
          if (i == 0) begin qb0.push_back(mosi[i]); qd0.push_back(dc[i]); end
          if (i == 1) begin qb1.push_back(mosi[i]); qd1.push_back(dc[i]); end
        end
        if (fb[i]) begin
          if (nfb[i] > 0 && (cyc - fb_prev[i]) != per[i]) bad_sp[i]++;
          if (bitcnt[i] != 88 + 16 * nfb[i]) bad_al[i]++;
          if (sck[i] || !dc[i]) bad_al[i]++;
          fb_prev[i] = cyc;
          nfb[i]++;
        end
        if (done[i]) begin
          if (done_n[i] < 4) begin
            done_cyc[i][done_n[i]]  = cyc;
            done_busy[i][done_n[i]] = busy[i];
          end
          done_n[i]++;
        end
        if (cs[i] && !pcs[i]) cs_rise[i] = cyc;
      end
      if (bmon && !busy[2]) busy_drop++;
    end
    psck = sck;
    pcs  = cs;
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [15:0] val;
    logic        dc;
    int          nb;
  } vec_t;

  vec_t tbl [23];

  task automatic pulse_clr();
    @(negedge clk); #1 clr = 1'b1;
    @(negedge clk); #1 clr = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] hb [11];
    logic       hd [11];
    int t0, pos, ok, dcok;
    logic [15:0] w;
    logic b, d;

    hb = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h03, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h02, 8'h2C};
    hd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 11; k++) begin
      tbl[k].val = {8'h00, hb[k]}; tbl[k].dc = hd[k]; tbl[k].nb = 8;
    end
    for (int k = 0; k < 12; k++) begin
      tbl[11 + k].val = 16'hA000 + 16'(k); tbl[11 + k].dc = 1'b1; tbl[11 + k].nb = 16;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;
    pulse_clr();

    // Reset while a frame is mid-shift in the pixel phase
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    repeat (401) @(negedge clk);
    chk("pre_reset_cs_low", int'(cs[0]), 0);
    chk("pre_reset_busy", int'(busy[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("reset_cs", int'(cs[0]), 1);
    chk("reset_sck", int'(sck[0]), 0);
    chk("reset_mosi", int'(mosi[0]), 0);
    chk("reset_dc", int'(dc[0]), 1);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_fbclk", int'(fb[0]), 0);
    @(negedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("reset_no_frame_done", done_n[0], 0);
    chk("reset_stays_idle_cs", int'(cs[0]), 1);
    pulse_clr();

    // Full frames on all three instances
    @(negedge clk); start = 3'b111;
    @(negedge clk); start = 3'b000;
    t0 = cyc;
    bmon = 1'b1;
    repeat (100) @(negedge clk);
    start[0] = 1'b1; start[2] = 1'b1;
    @(negedge clk); start[0] = 1'b0; start[2] = 1'b0;
    repeat (500) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;

    for (int k = 0; k < 4000 && !(done_n[0] >= 1 && done_n[1] >= 1 && done_n[2] >= 2); k++)
      @(negedge clk);
    chk("frame_done_within_budget",
        int'(done_n[0] >= 1 && done_n[1] >= 1 && done_n[2] >= 2), 1);
    repeat (60) @(negedge clk);
    bmon = 1'b0;

    chk("a_latency", done_cyc[0][0] - t0, 1137);
    chk("a_done_count", done_n[0], 1);
    chk("a_busy_falls_with_done", int'(done_busy[0][0]), 0);
    chk("a_cs_high_before_done", done_cyc[0][0] - cs_rise[0], 17);
    chk("a_pulse_count", nfb[0], 12);
    chk("a_pulse_spacing_errors", bad_sp[0], 0);
    chk("a_pulse_alignment_errors", bad_al[0], 0);
    chk("a_cs_high_during_bits", cs_bad[0], 0);
    chk("a_bit_count", qb0.size(), 280);

    chk("b_latency", done_cyc[1][0] - t0, 577);
    chk("b_done_count", done_n[1], 1);
    chk("b_pulse_count", nfb[1], 12);
    chk("b_pulse_spacing_errors", bad_sp[1], 0);
    chk("b_pulse_alignment_errors", bad_al[1], 0);
    chk("b_bit_count", qb1.size(), 280);

    chk("c_latency", done_cyc[2][0] - t0, 1137);
    chk("c_frame_period", done_cyc[2][1] - done_cyc[2][0], 1137);
    chk("c_busy_at_done", int'(done_busy[2][0]), 1);
    chk("c_busy_never_drops", busy_drop, 0);

    // Captured stream vs expected header bytes and pixel words
    for (int dut = 0; dut < 2; dut++) begin
      pos = 0;
      for (int e = 0; e < 23; e++) begin
        w = '0; dcok = 1;
        for (int j = 0; j < tbl[e].nb; j++) begin
          ok = (dut == 0) ? int'(pos < qb0.size()) : int'(pos < qb1.size());
          if (ok != 0) begin
            b = (dut == 0) ? qb0[pos] : qb1[pos];
            d = (dut == 0) ? qd0[pos] : qd1[pos];
          end else begin
            b = 1'bx; d = 1'bx;
          end
          w = {w[14:0], b};
          if (d !== tbl[e].dc) dcok = 0;
          pos++;
        end
        chk($sformatf("%s_word%0d", (dut == 0) ? "a" : "b", e), int'(w), int'(tbl[e].val));
        chk($sformatf("%s_dc%0d", (dut == 0) ? "a" : "b", e), dcok, 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
